// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with valid/ready handshakes: accepts A, B and carry-in, adds LSB first
// one bit per clock, and holds the registered sum/carry-out until the consumer takes it.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             serial_adder_clk,
  input  logic             serial_adder_rst,
  input  logic             serial_adder_start_valid,
  output logic             serial_adder_start_ready,
  input  logic [WIDTH-1:0] serial_adder_a,
  input  logic [WIDTH-1:0] serial_adder_b,
  input  logic             serial_adder_cin,
  output logic [WIDTH-1:0] serial_adder_sum,
  output logic             serial_adder_cout,
  output logic             serial_adder_out_valid,
  input  logic             serial_adder_out_ready,
  output logic             serial_adder_busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             start_ready_q, start_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  // One full-adder bit built from two half-adder stages
  logic ha1_s_c, ha1_c_c, ha2_c_c, bit_s_c, carry_nxt_c;

  always_comb begin
    ha1_s_c     = a_sh_q[0] ^ b_sh_q[0];
    ha1_c_c     = a_sh_q[0] & b_sh_q[0];
    bit_s_c     = ha1_s_c ^ carry_q;
    ha2_c_c     = ha1_s_c & carry_q;
    carry_nxt_c = ha1_c_c | ha2_c_c;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (serial_adder_start_valid && start_ready_q) begin
          a_sh_d  = serial_adder_a;
          b_sh_d  = serial_adder_b;
          carry_d = serial_adder_cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d   = {bit_s_c, res_q[WIDTH-1:1]};
        carry_d = carry_nxt_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {bit_s_c, res_q[WIDTH-1:1]};
          cout_d  = carry_nxt_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (serial_adder_out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    start_ready_d = (state_d == IDLE);
    out_valid_d   = (state_d == DONE);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge serial_adder_clk or posedge serial_adder_rst) begin
    if (serial_adder_rst) begin
      state_q       <= IDLE;
      a_sh_q        <= '0;
      b_sh_q        <= '0;
      res_q         <= '0;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      start_ready_q <= 1'b1;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_sh_q        <= a_sh_d;
      b_sh_q        <= b_sh_d;
      res_q         <= res_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      sum_q         <= sum_d;
      cout_q        <= cout_d;
      start_ready_q <= start_ready_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign serial_adder_start_ready = start_ready_q;
  assign serial_adder_sum         = sum_q;
  assign serial_adder_cout        = cout_q;
  assign serial_adder_out_valid   = out_valid_q;
  assign serial_adder_busy        = busy_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: a reference a+b+cin model feeds a scoreboard queue
// that is popped when out_valid rises.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned MAX_WAIT = 40;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .serial_adder_clk        (clk),
    .serial_adder_rst        (rst),
    .serial_adder_start_valid(start_valid),
    .serial_adder_start_ready(start_ready),
    .serial_adder_a          (a),
    .serial_adder_b          (b),
    .serial_adder_cin        (cin),
    .serial_adder_sum        (sum),
    .serial_adder_cout       (cout),
    .serial_adder_out_valid  (out_valid),
    .serial_adder_out_ready  (out_ready),
    .serial_adder_busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mc);
    logic [WIDTH:0] full;
    exp_t e;
    full   = {1'b0, ma} + {1'b0, mb} + (WIDTH+1)'(mc);
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    return e;
  endfunction

  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start_valid = 1'b1;
    @(posedge clk); #1;
    check("accept_busy", 32'(busy), 32'd1);
    sb.push_back(model(ta, tb_, tc));
    start_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency and pops the scoreboard; optionally drives junk while busy
  task automatic wait_result(input bit junk, output exp_t got);
    int lat;
    exp_t e;
    lat = 0;
    e = '0;
    if (junk) begin
      a = '1; b = '1; cin = 1'b1; start_valid = 1'b1;
    end
    for (int n = 1; n <= MAX_WAIT; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
      check("ready_low_busy", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    check("latency", 32'(lat), 32'(WIDTH));
    if (sb.size() > 0) e = sb.pop_front();
    check("sum", 32'(sum), 32'(e.sum));
    check("cout", 32'(cout), 32'(e.cout));
    got = e;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_out_valid", 32'(out_valid), 32'd0);
    check("hs_start_ready", 32'(start_ready), 32'd1);
    check("hs_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t r;
    rst = 1'b0; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Carry ripples through every bit
    start_op(8'hFF, 8'h01, 1'b0);
    wait_result(1'b0, r);
    check("ff01_sum", 32'(sum), 32'h00);
    check("ff01_cout", 32'(cout), 32'd1);
    handshake();

    start_op(8'h0F, 8'hF0, 1'b1);
    wait_result(1'b0, r);
    handshake();
    start_op(8'h01, 8'h01, 1'b0);
    wait_result(1'b0, r);
    handshake();
    start_op(8'h00, 8'h00, 1'b0);
    wait_result(1'b0, r);
    handshake();

    // Operand and start_valid noise during RUN must not disturb the result
    start_op(8'h12, 8'h34, 1'b0);
    wait_result(1'b1, r);
    check("noise_sum", 32'(sum), 32'h46);

    // Backpressure: result must hold while out_ready is low
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(r.sum));
      check("hold_cout", 32'(cout), 32'(r.cout));
    end
    handshake();
    check("retain_sum", 32'(sum), 32'(r.sum));

    // start_valid held through DONE is taken on the first IDLE edge
    start_op(8'hA5, 8'h5B, 1'b1);
    wait_result(1'b0, r);
    @(negedge clk);
    out_ready = 1'b1; start_valid = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("spacing_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("spacing_accept", 32'(busy), 32'd1);
    sb.push_back(model(8'h01, 8'h01, 1'b0));
    start_valid = 1'b0;
    wait_result(1'b0, r);
    handshake();

    // Asynchronous reset in the middle of RUN discards the operation
    start_op(8'h55, 8'h0A, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrun_busy", 32'(busy), 32'd0);
    check("midrun_ready", 32'(start_ready), 32'd1);
    check("midrun_valid", 32'(out_valid), 32'd0);
    check("midrun_sum", 32'(sum), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    check("inrst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0; start_valid = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
    @(posedge clk); #1;
    check("post_rst_accept", 32'(busy), 32'd1);
    sb.push_back(model(8'h80, 8'h80, 1'b0));
    start_valid = 1'b0;
    wait_result(1'b0, r);
    check("post_rst_sum", 32'(sum), 32'h00);
    check("post_rst_cout", 32'(cout), 32'd1);
    handshake();

    // out_ready while idle is ignored
    @(negedge clk) out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_ready_busy", 32'(busy), 32'd0);
    check("idle_ready_sum", 32'(sum), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
